// File: rtl/mem_port_bridge.sv
// Serves the core's split instruction/data ports from one 64-bit physical memory port.
// Partial stores are done by read-modify-write; an optional one-line buffer serves repeat fetches.
module mem_port_bridge #(
  parameter bit LINE_BUF_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [31:0] instr_mem_address,
  output logic        instr_mem_resp,
  output logic [31:0] instr_mem_rdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_mbe,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_wdata,
  output logic        data_mem_resp,
  output logic [31:0] data_mem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [63:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [63:0] pmem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_WB,
    S_RESP
  } state_t;

  state_t      r_state, w_state_next;

  logic        r_sel_hi, w_sel_hi_next;
  logic        r_is_data, w_is_data_next;
  logic        r_is_store, w_is_store_next;
  logic [3:0]  r_mbe, w_mbe_next;
  logic [31:0] r_wdata, w_wdata_next;
  logic [63:0] r_line, w_line_next;

  logic        r_buf_valid, w_buf_valid_next;
  logic [28:0] r_buf_tag, w_buf_tag_next;
  logic [63:0] r_buf_line, w_buf_line_next;

  logic        r_instr_resp, w_instr_resp_next;
  logic [31:0] r_instr_rdata, w_instr_rdata_next;
  logic        r_data_resp, w_data_resp_next;
  logic [31:0] r_data_rdata, w_data_rdata_next;
  logic        r_pmem_read, w_pmem_read_next;
  logic        r_pmem_write, w_pmem_write_next;
  logic [31:0] r_pmem_address, w_pmem_address_next;
  logic [63:0] r_pmem_wdata, w_pmem_wdata_next;

  logic        w_hit;
  logic [31:0] w_old_half;
  logic [31:0] w_new_half;
  logic [63:0] w_merged;
  logic        w_unused;

  // Only the line address and the half-select bit matter; byte offsets are always zero.
  assign w_unused = ^{instr_mem_address[1:0], data_mem_address[1:0]};

  assign w_hit = LINE_BUF_EN && r_buf_valid && (r_buf_tag == instr_mem_address[31:3]);

  assign w_old_half = r_sel_hi ? r_line[63:32] : r_line[31:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge_byte
      assign w_new_half[gi*8 +: 8] = r_mbe[gi] ? r_wdata[gi*8 +: 8] : w_old_half[gi*8 +: 8];
    end
  endgenerate

  assign w_merged = r_sel_hi ? {w_new_half, r_line[31:0]} : {r_line[63:32], w_new_half};

  always_comb begin
    w_state_next        = r_state;
    w_sel_hi_next       = r_sel_hi;
    w_is_data_next      = r_is_data;
    w_is_store_next     = r_is_store;
    w_mbe_next          = r_mbe;
    w_wdata_next        = r_wdata;
    w_line_next         = r_line;
    w_buf_valid_next    = r_buf_valid;
    w_buf_tag_next      = r_buf_tag;
    w_buf_line_next     = r_buf_line;
    w_instr_resp_next   = 1'b0;
    w_instr_rdata_next  = 32'h0;
    w_data_resp_next    = 1'b0;
    w_data_rdata_next   = 32'h0;
    w_pmem_read_next    = r_pmem_read;
    w_pmem_write_next   = r_pmem_write;
    w_pmem_address_next = r_pmem_address;
    w_pmem_wdata_next   = r_pmem_wdata;

    case (r_state)
      S_IDLE: begin
        if (data_write) begin
          w_is_data_next   = 1'b1;
          w_is_store_next  = 1'b1;
          w_sel_hi_next    = data_mem_address[2];
          w_mbe_next       = data_mbe;
          w_wdata_next     = data_mem_wdata;
          w_buf_valid_next = 1'b0;
          if (data_mbe == 4'b0000) begin
            w_state_next     = S_RESP;
            w_data_resp_next = 1'b1;
          end else begin
            w_state_next        = S_RD;
            w_pmem_read_next    = 1'b1;
            w_pmem_address_next = {data_mem_address[31:3], 3'b000};
          end
        end else if (data_read) begin
          w_is_data_next      = 1'b1;
          w_is_store_next     = 1'b0;
          w_sel_hi_next       = data_mem_address[2];
          w_state_next        = S_RD;
          w_pmem_read_next    = 1'b1;
          w_pmem_address_next = {data_mem_address[31:3], 3'b000};
        end else if (instr_read) begin
          w_is_data_next  = 1'b0;
          w_is_store_next = 1'b0;
          w_sel_hi_next   = instr_mem_address[2];
          if (w_hit) begin
            w_state_next       = S_RESP;
            w_instr_resp_next  = 1'b1;
            w_instr_rdata_next = instr_mem_address[2] ? r_buf_line[63:32] : r_buf_line[31:0];
          end else begin
            w_state_next        = S_RD;
            w_pmem_read_next    = 1'b1;
            w_pmem_address_next = {instr_mem_address[31:3], 3'b000};
          end
        end
      end

      S_RD: begin
        if (pmem_resp) begin
          w_pmem_read_next = 1'b0;
          w_line_next      = pmem_rdata;
          if (r_is_store) begin
            w_state_next = S_MERGE;
          end else begin
            w_state_next = S_RESP;
            if (r_is_data) begin
              w_data_resp_next  = 1'b1;
              w_data_rdata_next = r_sel_hi ? pmem_rdata[63:32] : pmem_rdata[31:0];
            end else begin
              w_instr_resp_next  = 1'b1;
              w_instr_rdata_next = r_sel_hi ? pmem_rdata[63:32] : pmem_rdata[31:0];
              if (LINE_BUF_EN) begin
                w_buf_valid_next = 1'b1;
                w_buf_tag_next   = r_pmem_address[31:3];
                w_buf_line_next  = pmem_rdata;
              end
            end
          end
        end
      end

      S_MERGE: begin
        w_state_next      = S_WB;
        w_pmem_write_next = 1'b1;
        w_pmem_wdata_next = w_merged;
      end

      S_WB: begin
        if (pmem_resp) begin
          w_pmem_write_next = 1'b0;
          w_state_next      = S_RESP;
          w_data_resp_next  = 1'b1;
        end
      end

      S_RESP: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_sel_hi       <= 1'b0;
      r_is_data      <= 1'b0;
      r_is_store     <= 1'b0;
      r_mbe          <= 4'h0;
      r_wdata        <= 32'h0;
      r_line         <= 64'h0;
      r_buf_valid    <= 1'b0;
      r_buf_tag      <= 29'h0;
      r_buf_line     <= 64'h0;
      r_instr_resp   <= 1'b0;
      r_instr_rdata  <= 32'h0;
      r_data_resp    <= 1'b0;
      r_data_rdata   <= 32'h0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= 32'h0;
      r_pmem_wdata   <= 64'h0;
    end else begin
      r_state        <= w_state_next;
      r_sel_hi       <= w_sel_hi_next;
      r_is_data      <= w_is_data_next;
      r_is_store     <= w_is_store_next;
      r_mbe          <= w_mbe_next;
      r_wdata        <= w_wdata_next;
      r_line         <= w_line_next;
      r_buf_valid    <= w_buf_valid_next;
      r_buf_tag      <= w_buf_tag_next;
      r_buf_line     <= w_buf_line_next;
      r_instr_resp   <= w_instr_resp_next;
      r_instr_rdata  <= w_instr_rdata_next;
      r_data_resp    <= w_data_resp_next;
      r_data_rdata   <= w_data_rdata_next;
      r_pmem_read    <= w_pmem_read_next;
      r_pmem_write   <= w_pmem_write_next;
      r_pmem_address <= w_pmem_address_next;
      r_pmem_wdata   <= w_pmem_wdata_next;
    end
  end

  assign instr_mem_resp  = r_instr_resp;
  assign instr_mem_rdata = r_instr_rdata;
  assign data_mem_resp   = r_data_resp;
  assign data_mem_rdata  = r_data_rdata;
  assign pmem_read       = r_pmem_read;
  assign pmem_write      = r_pmem_write;
  assign pmem_address    = r_pmem_address;
  assign pmem_wdata      = r_pmem_wdata;

endmodule

// File: tb/tb_mem_port_bridge.sv
// Directed bench for mem_port_bridge: reset abort, fetch miss/hit, RMW stores,
// arbitration and line-buffer invalidation, with hand-computed expectations.
module tb_mem_port_bridge;

  logic        clk;
  logic        rst;
  logic        instr_read;
  logic [31:0] instr_mem_address;
  logic        instr_mem_resp;
  logic [31:0] instr_mem_rdata;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_mem_address;
  logic [31:0] data_mem_wdata;
  logic        data_mem_resp;
  logic [31:0] data_mem_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic        pmem_resp;
  logic [63:0] pmem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_bridge #(.LINE_BUF_EN(1'b1)) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_read        (instr_read),
    .instr_mem_address (instr_mem_address),
    .instr_mem_resp    (instr_mem_resp),
    .instr_mem_rdata   (instr_mem_rdata),
    .data_read         (data_read),
    .data_write        (data_write),
    .data_mbe          (data_mbe),
    .data_mem_address  (data_mem_address),
    .data_mem_wdata    (data_mem_wdata),
    .data_mem_resp     (data_mem_resp),
    .data_mem_rdata    (data_mem_rdata),
    .pmem_read         (pmem_read),
    .pmem_write        (pmem_write),
    .pmem_address      (pmem_address),
    .pmem_wdata        (pmem_wdata),
    .pmem_resp         (pmem_resp),
    .pmem_rdata        (pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) at falling edges for pmem_read (which=0) or pmem_write (which=1).
  task automatic wait_pmem(input string tag, input int which);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((which == 0) ? pmem_read : pmem_write) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {63'h0, seen}, 64'h1);
  endtask

  task automatic pmem_reply(input logic [63:0] rdata);
    pmem_resp  = 1'b1;
    pmem_rdata = rdata;
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = 64'h0;
  endtask

  initial begin
    rst = 1'b0;
    instr_read = 1'b0; instr_mem_address = 32'h0;
    data_read = 1'b0; data_write = 1'b0; data_mbe = 4'h0;
    data_mem_address = 32'h0; data_mem_wdata = 32'h0;
    pmem_resp = 1'b0; pmem_rdata = 64'h0;

    repeat (2) @(negedge clk);
    chk("rst_pmem_read", {63'h0, pmem_read}, 64'h0);
    chk("rst_resps", {62'h0, instr_mem_resp, data_mem_resp}, 64'h0);
    chk("rst_pmem_addr", {32'h0, pmem_address}, 64'h0);
    rst = 1'b1;

    // 1: reset while a load is waiting on pmem
    @(negedge clk);
    data_read = 1'b1; data_mem_address = 32'h100;
    @(negedge clk);
    chk("t1_pmem_read", {63'h0, pmem_read}, 64'h1);
    chk("t1_pmem_addr", {32'h0, pmem_address}, 64'h100);
    #2 rst = 1'b0;
    #1;
    chk("t1_async_read", {63'h0, pmem_read}, 64'h0);
    chk("t1_async_addr", {32'h0, pmem_address}, 64'h0);
    chk("t1_async_resps", {62'h0, instr_mem_resp, data_mem_resp}, 64'h0);
    data_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pmem_reply(64'h1234_5678_9ABC_DEF0);
    chk("t1_stale_resps", {62'h0, instr_mem_resp, data_mem_resp}, 64'h0);
    @(negedge clk);
    chk("t1_stale_resps2", {62'h0, instr_mem_resp, data_mem_resp}, 64'h0);
    chk("t1_stale_pmem", {62'h0, pmem_read, pmem_write}, 64'h0);

    // 2: fetch miss then line-buffer hit
    instr_read = 1'b1; instr_mem_address = 32'h60;
    wait_pmem("t2_miss_read", 0);
    chk("t2_miss_addr", {32'h0, pmem_address}, 64'h60);
    @(negedge clk);
    @(negedge clk);
    chk("t2_read_held", {63'h0, pmem_read}, 64'h1);
    pmem_reply(64'hAAAA_BBBB_CCCC_DDDD);
    chk("t2_miss_resp", {62'h0, instr_mem_resp, data_mem_resp}, 64'h2);
    chk("t2_miss_rdata", {32'h0, instr_mem_rdata}, 64'hCCCC_DDDD);
    chk("t2_miss_read_drop", {63'h0, pmem_read}, 64'h0);
    instr_read = 1'b0;
    @(negedge clk);
    chk("t2_resp_pulse", {63'h0, instr_mem_resp}, 64'h0);
    instr_read = 1'b1; instr_mem_address = 32'h64;
    @(negedge clk);
    chk("t2_hit_resp", {62'h0, instr_mem_resp, data_mem_resp}, 64'h2);
    chk("t2_hit_rdata", {32'h0, instr_mem_rdata}, 64'hAAAA_BBBB);
    chk("t2_hit_no_pmem", {63'h0, pmem_read}, 64'h0);
    instr_read = 1'b0;
    @(negedge clk);

    // 3: byte store read-modify-write into the upper half
    data_write = 1'b1; data_mem_address = 32'h84; data_mbe = 4'b0010;
    data_mem_wdata = 32'h0000_EE00;
    wait_pmem("t3_rd", 0);
    chk("t3_rd_addr", {32'h0, pmem_address}, 64'h80);
    pmem_reply(64'h1122_3344_5566_7788);
    wait_pmem("t3_wb", 1);
    chk("t3_wb_addr", {32'h0, pmem_address}, 64'h80);
    chk("t3_wb_data", pmem_wdata, 64'h1122_EE44_5566_7788);
    chk("t3_wb_no_read", {63'h0, pmem_read}, 64'h0);
    pmem_reply(64'h0);
    chk("t3_resp", {62'h0, instr_mem_resp, data_mem_resp}, 64'h1);
    chk("t3_rdata", {32'h0, data_mem_rdata}, 64'h0);
    data_write = 1'b0; data_mbe = 4'h0;
    @(negedge clk);
    chk("t3_single_resp", {63'h0, data_mem_resp}, 64'h0);

    // 4: simultaneous fetch and load, data first
    instr_read = 1'b1; instr_mem_address = 32'h10;
    data_read = 1'b1; data_mem_address = 32'h200;
    wait_pmem("t4_data_rd", 0);
    chk("t4_data_addr", {32'h0, pmem_address}, 64'h200);
    pmem_reply(64'h0123_4567_89AB_CDEF);
    chk("t4_data_resp", {62'h0, instr_mem_resp, data_mem_resp}, 64'h1);
    chk("t4_data_rdata", {32'h0, data_mem_rdata}, 64'h89AB_CDEF);
    data_read = 1'b0;
    wait_pmem("t4_fetch_rd", 0);
    chk("t4_fetch_addr", {32'h0, pmem_address}, 64'h10);
    pmem_reply(64'hFFFF_0000_1234_5678);
    chk("t4_fetch_resp", {62'h0, instr_mem_resp, data_mem_resp}, 64'h2);
    chk("t4_fetch_rdata", {32'h0, instr_mem_rdata}, 64'h1234_5678);
    instr_read = 1'b0;
    @(negedge clk);

    // 5: a store to the buffered line forces the next fetch back to pmem
    instr_read = 1'b1; instr_mem_address = 32'h60;
    wait_pmem("t5_fill_rd", 0);
    pmem_reply(64'hAAAA_BBBB_CCCC_DDDD);
    chk("t5_fill_rdata", {32'h0, instr_mem_rdata}, 64'hCCCC_DDDD);
    instr_read = 1'b0;
    @(negedge clk);
    data_write = 1'b1; data_mem_address = 32'h60; data_mbe = 4'b1111;
    data_mem_wdata = 32'hDEAD_BEEF;
    wait_pmem("t5_st_rd", 0);
    pmem_reply(64'hAAAA_BBBB_CCCC_DDDD);
    wait_pmem("t5_st_wb", 1);
    chk("t5_wb_data", pmem_wdata, 64'hAAAA_BBBB_DEAD_BEEF);
    pmem_reply(64'h0);
    chk("t5_st_resp", {62'h0, instr_mem_resp, data_mem_resp}, 64'h1);
    data_write = 1'b0; data_mbe = 4'h0;
    @(negedge clk);
    instr_read = 1'b1; instr_mem_address = 32'h60;
    wait_pmem("t5_refetch_rd", 0);
    chk("t5_refetch_addr", {32'h0, pmem_address}, 64'h60);
    pmem_reply(64'hAAAA_BBBB_DEAD_BEEF);
    chk("t5_refetch_resp", {62'h0, instr_mem_resp, data_mem_resp}, 64'h2);
    chk("t5_refetch_rdata", {32'h0, instr_mem_rdata}, 64'hDEAD_BEEF);
    instr_read = 1'b0;
    @(negedge clk);

    // 6: store with no byte enables completes without touching pmem
    data_write = 1'b1; data_mem_address = 32'h40; data_mbe = 4'b0000;
    data_mem_wdata = 32'h5555_5555;
    @(negedge clk);
    chk("t6_resp", {62'h0, instr_mem_resp, data_mem_resp}, 64'h1);
    chk("t6_rdata", {32'h0, data_mem_rdata}, 64'h0);
    chk("t6_no_pmem", {62'h0, pmem_read, pmem_write}, 64'h0);
    data_write = 1'b0;
    @(negedge clk);
    chk("t6_after", {61'h0, pmem_read, pmem_write, data_mem_resp}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_bridge.md
Name: mem_port_bridge

Overview:
Responder for the core's split 32-bit instruction/data memory ports (instr_read/instr_mem_*, data_read/data_write/data_mbe/data_mem_*). It services both ports from the single 64-bit physical memory interface (pmem_*) and arbitrates between them. Sub-word and sub-line stores are done by read-modify-write. An optional one-line buffer short-circuits sequential instruction fetches. Sits between mp4 core logic and physical memory for CP2.

Parameters:
LINE_BUF_EN, 1, 1 = enable the single 64-bit instruction line buffer; 0 = every fetch goes to pmem.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
instr_read  in  1  instruction fetch request, held until instr_mem_resp
instr_mem_address  in  32  fetch address, word aligned
instr_mem_resp  out  1  one-cycle fetch completion pulse
instr_mem_rdata  out  32  fetch data, valid while instr_mem_resp=1
data_read  in  1  load request, held until data_mem_resp
data_write  in  1  store request, held until data_mem_resp
data_mbe  in  4  store byte enables relative to word address
data_mem_address  in  32  load/store address, word aligned
data_mem_wdata  in  32  store data, byte lanes already aligned to data_mbe
data_mem_resp  out  1  one-cycle load/store completion pulse
data_mem_rdata  out  32  load data, valid while data_mem_resp=1
pmem_read  out  1  physical read request
pmem_write  out  1  physical write request
pmem_address  out  32  physical address, always {addr[31:3],3'b000}
pmem_wdata  out  64  physical write data
pmem_resp  in  1  one-cycle physical completion
pmem_rdata  in  64  physical read data, valid with pmem_resp

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, line buffer invalid. All outputs 0: resp pulses, rdata, pmem_read/write, pmem_address, pmem_wdata. An in-flight pmem transaction is abandoned; a pmem_resp arriving after reset release while in IDLE is ignored.
- FSM states: IDLE, RD, MERGE, WB, RESP. All outputs are registered.
- IDLE arbitration:
  - data port has priority over the instruction port.
  - data_write wins if data_read and data_write are both asserted.
  - Requests are sampled only in IDLE.
- Load (data_read): IDLE -> RD. pmem_read=1 with the line address, held until pmem_resp. On pmem_resp, latch pmem_rdata and go to RESP.
- Fetch miss: same path as a load. If LINE_BUF_EN=1, the latched line and its tag addr[31:3] are written into the buffer and it is marked valid.
- Fetch hit: LINE_BUF_EN=1, buffer valid, tag == instr_mem_address[31:3]. IDLE -> RESP directly, no pmem access.
- Store (data_write), mbe != 0:
  - IDLE -> RD (read line) -> MERGE (one cycle).
  - MERGE builds the new line: addr[2]=0 targets bits[31:0], addr[2]=1 targets bits[63:32]. Byte i of that half takes wdata byte i when mbe[i]=1, otherwise keeps the old byte.
  - WB: pmem_write=1 with merged pmem_wdata, held until pmem_resp -> RESP.
- Store with mbe=4'b0000: IDLE -> RESP, no pmem access.
- Any store invalidates the line buffer on the cycle it leaves IDLE.
- RESP (exactly one cycle):
  - Assert the serving port's resp only.
  - rdata = addr[2] ? line[63:32] : line[31:0]. For stores, data_mem_rdata = 0.
  - Then go to IDLE. The core must drop or replace its request by the cycle after resp. A request still high in IDLE is treated as a new request.
- pmem_read and pmem_write are never high together. Their address and data are stable while asserted.
- Latency from the request-high cycle T in IDLE:
  - fetch hit: resp at T+1.
  - read miss: resp 1 cycle after pmem_resp.
  - store: resp 1 cycle after the WB pmem_resp (RD + MERGE + WB).
- Arbitration loss: a fetch pending while a data op is served is handled in the IDLE cycle after RESP, unless a data request is again present.

Test Plan:
1. Reset mid-RD: assert data_read addr 0x100, pmem_resp never returns, pull rst low -> pmem_read=0 immediately, all outputs 0; after release, a stale pmem_resp is ignored and no resp pulses.
2. Fetch miss then hit: instr_read 0x60, pmem returns 0xAAAA_BBBB_CCCC_DDDD after 3 cycles -> pmem_address=0x60, instr_mem_rdata=0xCCCCDDDD. Then fetch 0x64 -> resp next cycle, rdata=0xAAAABBBB, pmem_read stays 0.
3. Byte store RMW: line at 0x80 = 0x1122_3344_5566_7788; store addr 0x84, mbe=4'b0010, wdata=0x0000EE00 -> pmem_wdata=0x1122_EE44_5566_7788 at 0x80, one data_mem_resp.
4. Simultaneous requests: instr_read 0x10 and data_read 0x200 in the same cycle -> the data read completes first, then the fetch; exactly one resp per port, never both in one cycle.
5. Store invalidates buffer: fetch 0x60 (fills buffer); store sw 0x60 wdata 0xDEADBEEF; fetch 0x60 -> pmem_read reissued, rdata=0xDEADBEEF.
6. mbe=0 store: data_write, mbe=0 -> data_mem_resp one cycle later, pmem_read/pmem_write never asserted.
